// File: rtl/aes_key_expander.sv
// aes_key_expander: AES round-key generator and sole writer of the round-key
// memory. A start pulse clears the memory's valid bits, then one 128-bit round
// key per cycle is written to slots 0..num_rounds.
// Optional feature macro: AES256_EN (compiles in the AES-256 key schedule).
// Without it, key_len and cipher_key[127:0] are ignored and 10 rounds are used.

// Combinational AES S-box: multiplicative inverse in GF(2^8), then affine map.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      bb = bb >> 1;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^-1 for x != 0, and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv_byte;

  // Inverse followed by the fixed affine transform
  always_comb begin
    inv_byte = gf_inv(in_byte);
    out_byte = inv_byte
             ^ {inv_byte[6:0], inv_byte[7]}
             ^ {inv_byte[5:0], inv_byte[7:6]}
             ^ {inv_byte[4:0], inv_byte[7:5]}
             ^ {inv_byte[3:0], inv_byte[7:4]}
             ^ 8'h63;
  end

endmodule

module aes_key_expander (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         key_len,
  input  logic [255:0] cipher_key,
  output logic         busy,
  output logic         done,
  output logic [3:0]   num_rounds,
  output logic         kmem_reset_valid_bits,
  output logic         kmem_w_en,
  output logic [3:0]   kmem_waddr,
  output logic [127:0] kmem_wkey
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD0,
    S_LOAD1,
    S_EXPAND,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   nr_q, nr_d;
  // hist1 holds rk[r-1]; hist0 (AES-256 only) holds rk[r-2]
  logic [127:0] hist1_q, hist1_d;
`ifdef AES256_EN
  logic [127:0] hist0_q, hist0_d;
  logic         len256_q, len256_d;
`else
  logic         unused_inputs;
  assign unused_inputs = ^{key_len, cipher_key[127:0]};
`endif

  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         rvb_q, rvb_d;
  logic         wen_q, wen_d;
  logic [3:0]   waddr_q, waddr_d;
  logic [127:0] wkey_q, wkey_d;

  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [7:0]   rcon;
  logic [127:0] base_key;
  logic [127:0] new_key;

  function automatic logic [7:0] rcon_lut(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // SubWord: one S-box per byte of the selected word
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (
        .in_byte  (sub_in[gi*8 +: 8]),
        .out_byte (sub_out[gi*8 +: 8])
      );
    end
  endgenerate

  // Next round key from the key history; AES-256 odd rounds skip RotWord/Rcon
  always_comb begin
    sub_in   = {hist1_q[23:0], hist1_q[31:24]};
    rcon     = rcon_lut(rnd_q);
    base_key = hist1_q;
`ifdef AES256_EN
    if (len256_q) begin
      base_key = hist0_q;
      if (rnd_q[0]) begin
        sub_in = hist1_q[31:0];
        rcon   = 8'h00;
      end else begin
        rcon   = rcon_lut({1'b0, rnd_q[3:1]});
      end
    end
`endif
    new_key[127:96] = base_key[127:96] ^ sub_out ^ {rcon, 24'h0};
    new_key[95:64]  = base_key[95:64] ^ new_key[127:96];
    new_key[63:32]  = base_key[63:32] ^ new_key[95:64];
    new_key[31:0]   = base_key[31:0]  ^ new_key[63:32];
  end

  // Next-state logic and next values of the registered outputs
  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    nr_d     = nr_q;
    hist1_d  = hist1_q;
`ifdef AES256_EN
    hist0_d  = hist0_q;
    len256_d = len256_q;
`endif
    busy_d   = (state_q != S_IDLE);
    done_d   = 1'b0;
    rvb_d    = 1'b0;
    wen_d    = 1'b0;
    waddr_d  = 4'd0;
    wkey_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
`ifdef AES256_EN
          len256_d = key_len;
          nr_d     = key_len ? 4'd14 : 4'd10;
          hist0_d  = cipher_key[255:128];
          hist1_d  = key_len ? cipher_key[127:0] : cipher_key[255:128];
`else
          nr_d     = 4'd10;
          hist1_d  = cipher_key[255:128];
`endif
        end
      end
      S_CLEAR: begin
        rvb_d   = 1'b1;
        state_d = S_LOAD0;
      end
      S_LOAD0: begin
        wen_d   = 1'b1;
        waddr_d = 4'd0;
`ifdef AES256_EN
        wkey_d  = hist0_q;
        if (len256_q) begin
          state_d = S_LOAD1;
        end else begin
          state_d = S_EXPAND;
          rnd_d   = 4'd1;
        end
`else
        wkey_d  = hist1_q;
        state_d = S_EXPAND;
        rnd_d   = 4'd1;
`endif
      end
`ifdef AES256_EN
      S_LOAD1: begin
        wen_d   = 1'b1;
        waddr_d = 4'd1;
        wkey_d  = hist1_q;
        state_d = S_EXPAND;
        rnd_d   = 4'd2;
      end
`endif
      S_EXPAND: begin
        wen_d   = 1'b1;
        waddr_d = rnd_q;
        wkey_d  = new_key;
        hist1_d = new_key;
`ifdef AES256_EN
        hist0_d = hist1_q;
`endif
        if (rnd_q == nr_q) begin
          state_d = S_DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, key history and output registers; reset abandons any run in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rnd_q    <= 4'd0;
      nr_q     <= 4'd0;
      hist1_q  <= '0;
`ifdef AES256_EN
      hist0_q  <= '0;
      len256_q <= 1'b0;
`endif
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rvb_q    <= 1'b0;
      wen_q    <= 1'b0;
      waddr_q  <= 4'd0;
      wkey_q   <= '0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      nr_q     <= nr_d;
      hist1_q  <= hist1_d;
`ifdef AES256_EN
      hist0_q  <= hist0_d;
      len256_q <= len256_d;
`endif
      busy_q   <= busy_d;
      done_q   <= done_d;
      rvb_q    <= rvb_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wkey_q   <= wkey_d;
    end
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign num_rounds            = nr_q;
  assign kmem_reset_valid_bits = rvb_q;
  assign kmem_w_en             = wen_q;
  assign kmem_waddr            = waddr_q;
  assign kmem_wkey             = wkey_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Testbench for aes_key_expander: FIPS-197 vectors from a table, randomized
// keys against a word-level key-schedule model, start-while-busy, start in
// DONE, and reset in the middle of a run.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         key_len;
  logic [255:0] cipher_key;
  logic         busy;
  logic         done;
  logic [3:0]   num_rounds;
  logic         kmem_reset_valid_bits;
  logic         kmem_w_en;
  logic [3:0]   kmem_waddr;
  logic [127:0] kmem_wkey;

  always #5 clk = ~clk;

  aes_key_expander dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .key_len               (key_len),
    .cipher_key            (cipher_key),
    .busy                  (busy),
    .done                  (done),
    .num_rounds            (num_rounds),
    .kmem_reset_valid_bits (kmem_reset_valid_bits),
    .kmem_w_en             (kmem_w_en),
    .kmem_waddr            (kmem_waddr),
    .kmem_wkey             (kmem_wkey)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sbox_t [256];
  logic [7:0]   rcon_t [11];
  logic [127:0] exp_rk [15];
  logic [127:0] got_rk [15];
  logic         got_v  [15];

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box table via the generator-3 walk of GF(2^8)
  task automatic build_tables();
    logic [7:0] p, q, x, rc;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
    rc = 8'h01;
    rcon_t[0] = 8'h00;
    for (int j = 1; j <= 10; j++) begin
      rcon_t[j] = rc;
      rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic eff_len(input logic l);
`ifdef AES256_EN
    return l;
`else
    return 1'b0;
`endif
  endfunction

  // FIPS-197 word-by-word key expansion
  task automatic model_expand(input logic [255:0] key, input logic len);
    logic [31:0] w [60];
    logic [31:0] t;
    int nk, nr;
    nk = len ? 8 : 4;
    nr = len ? 14 : 10;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++)
      exp_rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // One expansion run; poke_edge>0 raises start so it is sampled at that edge
  task automatic run_one(input string tag, input logic [255:0] key, input logic len,
                         input int poke_edge, output int done_cyc);
    int cyc, n_w, addr_err, busy_err, excl_err, bus_err, nr_err, rvb_cnt, rvb_cyc, done_cnt;
    int nr_e, exp_done;
    logic l;
    logic exp_busy;
    l = eff_len(len);
    nr_e = l ? 14 : 10;
    exp_done = l ? 17 : 13;
    model_expand(key, l);
    for (int r = 0; r < 15; r++) begin got_rk[r] = '0; got_v[r] = 1'b0; end
    n_w = 0; addr_err = 0; busy_err = 0; excl_err = 0; bus_err = 0; nr_err = 0;
    rvb_cnt = 0; rvb_cyc = -1; done_cnt = 0; done_cyc = -1;
    @(negedge clk);
    start = 1'b1; key_len = len; cipher_key = key;
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    start = 1'b0; cipher_key = ~key; key_len = ~len;
    while (cyc < exp_done + 3) begin
      if (cyc == poke_edge - 1) begin
        start = 1'b1;
        cipher_key = key ^ {8{32'h5a5a_1234}};
        key_len = ~len;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      exp_busy = (cyc >= 1 && cyc <= exp_done);
      if (busy !== exp_busy) busy_err++;
      if (kmem_reset_valid_bits && kmem_w_en) excl_err++;
      if (kmem_reset_valid_bits) begin rvb_cnt++; rvb_cyc = cyc; end
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (num_rounds !== nr_e[3:0]) nr_err++;
      if (kmem_w_en) begin
        if (kmem_waddr !== n_w[3:0] || cyc != 2 + n_w) addr_err++;
        got_rk[kmem_waddr] = kmem_wkey;
        got_v[kmem_waddr] = 1'b1;
        n_w++;
      end else if (kmem_waddr !== 4'd0 || kmem_wkey !== 128'h0) begin
        bus_err++;
      end
    end
    start = 1'b0;
    $display("run %s len=%0d done_cycle=%0d writes=%0d", tag, len, done_cyc, n_w);
    check({tag, ".done_cycle"}, done_cyc, exp_done);
    check({tag, ".done_pulses"}, done_cnt, 1);
    check({tag, ".clear_cycle"}, {rvb_cnt[7:0], rvb_cyc[7:0]}, {8'd1, 8'd1});
    check({tag, ".write_count"}, n_w, nr_e + 1);
    check({tag, ".addr_seq_errs"}, addr_err, 0);
    check({tag, ".busy_errs"}, busy_err, 0);
    check({tag, ".strobe_overlap"}, excl_err, 0);
    check({tag, ".idle_bus_errs"}, bus_err, 0);
    check({tag, ".num_rounds_errs"}, nr_err, 0);
    for (int r = 0; r < 15; r++) begin
      if (r <= nr_e) check($sformatf("%s.slot%0d", tag, r), got_rk[r], exp_rk[r]);
      else check($sformatf("%s.slot%0d_unwritten", tag, r), got_v[r], 1'b0);
    end
  endtask

  typedef struct {
    logic         len;
    logic [255:0] key;
    int           slot;
    logic [127:0] slot_val;
    int           nr;
    int           done_cyc;
    int           poke;
  } vec_t;

  vec_t vecs [5];

  localparam logic [127:0] K128    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_128 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10    = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [255:0] K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK14    = 128'hfe4890d1e6188d0b046df344706c631e;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    int wr_cnt;
    logic [255:0] rkey;
    logic rlen;

    build_tables();
    vecs[0] = '{1'b0, {K128, 128'h0}, 1, RK1_128, 10, 13, 0};
    vecs[1] = '{1'b0, {K128, 128'hdeadbeef_0badf00d_12345678_9abcdef0}, 10, RK10, 10, 13, 5};
    vecs[2] = '{1'b0, {K128, 128'h0}, 10, RK10, 10, 13, 13};
`ifdef AES256_EN
    vecs[3] = '{1'b1, K256, 14, RK14, 14, 17, 0};
    vecs[4] = '{1'b1, K256, 14, RK14, 14, 17, 17};
`else
    vecs[3] = '{1'b1, {K128, 128'h0}, 10, RK10, 10, 13, 0};
    vecs[4] = '{1'b1, {K128, 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a}, 1, RK1_128, 10, 13, 5};
`endif

    reset = 1'b0;
    start = 1'b0;
    key_len = 1'b0;
    cipher_key = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, num_rounds, kmem_reset_valid_bits, kmem_w_en, kmem_waddr, kmem_wkey},
          '0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_outputs", {busy, done, num_rounds, kmem_reset_valid_bits, kmem_w_en}, '0);

    for (int i = 0; i < 5; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].key, vecs[i].len, vecs[i].poke, dc);
      check($sformatf("vec%0d.fips_slot%0d", i, vecs[i].slot), got_rk[vecs[i].slot], vecs[i].slot_val);
      check($sformatf("vec%0d.num_rounds", i), num_rounds, vecs[i].nr);
      check($sformatf("vec%0d.done_cycle_tbl", i), dc, vecs[i].done_cyc);
    end

    // Reset asserted in cycle 7 of an AES-128 run
    @(negedge clk);
    start = 1'b1; key_len = 1'b0; cipher_key = {K128, 128'h0};
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    check("rst_mid.pre_write", {kmem_w_en, kmem_waddr}, {1'b1, 4'd5});
    reset = 1'b0;
    #1;
    check("rst_mid.outputs_zero",
          {busy, done, num_rounds, kmem_reset_valid_bits, kmem_w_en, kmem_waddr, kmem_wkey}, '0);
    wr_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (kmem_w_en || busy || done) wr_cnt++;
    end
    check("rst_mid.quiet_in_reset", wr_cnt, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid.quiet_after", {busy, kmem_w_en, kmem_reset_valid_bits}, 3'b000);
    run_one("after_reset", {K128, 128'h0}, 1'b0, 0, dc);
    check("after_reset.slot10", got_rk[10], RK10);
    $display("reset-mid-run sequence complete, fresh run done_cycle=%0d", dc);

    // Randomized keys against the model
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 8; k++) rkey[k*32 +: 32] = $urandom();
      rlen = 1'($urandom_range(0, 1));
      run_one($sformatf("rnd%0d", i), rkey, rlen, (i % 3 == 0) ? 6 : 0, dc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
